// File: rtl/shift_reg_seq_ctrl.sv
// Round-robin sequencer for a serial-in/parallel-out shift register: accepts a word
// from one of two requesters, shifts it out MSB-first, then reports the loopback result.
module shift_reg_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             sr_d,
  output logic             sr_en,
  input  logic [WIDTH-1:0] sr_q,
  output logic             done_valid,
  output logic [WIDTH-1:0] done_data,
  output logic             done_id,
  output logic             done_err,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    bit_idx;
  logic [WIDTH-1:0] data_q;
  logic             id_q;
  logic             last_grant;
  logic             grant0, grant1;
  logic             handshake;

  // The requester not served last wins a tie; a lone requester always wins.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    grant0     = 1'b0;
    grant1     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    grant0     = req0_valid & (~req1_valid | last_grant);
    grant1     = req1_valid & ~grant0;
    req0_ready = (state == IDLE) & ~reset & grant0;
    req1_ready = (state == IDLE) & ~reset & grant1;
  end

  assign handshake = req0_ready | req1_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (handshake) state_nxt = SHIFT;
      SHIFT:   if (cnt == CNT_LAST) state_nxt = CHECK;
      CHECK:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bit_idx = CNT_LAST - cnt;
    sr_en   = (state == SHIFT);
    sr_d    = sr_en & data_q[bit_idx];
    busy    = (state != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    // NOTE: sequential state always uses non-blocking assignment so every register
    // samples pre-edge values regardless of process ordering.
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the word holding register is reset too; it is a handful of flops, not a
      // memory, and a known value keeps sr_d deterministic after an aborted transfer.
      cnt        <= '0;
      data_q     <= '0;
      id_q       <= 1'b0;
      last_grant <= 1'b1;
      done_valid <= 1'b0;
      done_data  <= '0;
      done_id    <= 1'b0;
      done_err   <= 1'b0;
    end else begin
      done_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (handshake) begin
            data_q     <= req1_ready ? req1_data : req0_data;
            id_q       <= req1_ready;
            last_grant <= req1_ready;
            cnt        <= '0;
          end
        end
        SHIFT: begin
          if (cnt != CNT_LAST) cnt <= cnt + 1'b1;
        end
        CHECK: begin
          done_valid <= 1'b1;
          done_data  <= sr_q;
          done_id    <= id_q;
          done_err   <= (sr_q != data_q);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_reg_seq_ctrl.sv
// Scoreboard bench for shift_reg_seq_ctrl: a behavioural shift register closes the loop,
// stimulus pushes hand-computed results, and a monitor pops them on every done_valid.
module tb_shift_reg_seq_ctrl;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] data;
    logic         id;
    logic         err;
  } exp_t;

  logic         clk, reset;
  logic         req0_valid, req1_valid;
  logic [W-1:0] req0_data, req1_data;
  logic         req0_ready, req1_ready;
  logic         sr_d, sr_en;
  logic [W-1:0] sr_q, sr_model;
  logic         done_valid, done_id, done_err, busy;
  logic [W-1:0] done_data;
  logic         fault;

  int   checks = 0;
  int   errors = 0;
  int   done_seen = 0;
  exp_t exp_q[$];

  shift_reg_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .sr_d(sr_d), .sr_en(sr_en), .sr_q(sr_q),
    .done_valid(done_valid), .done_data(done_data), .done_id(done_id),
    .done_err(done_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // q0 takes d, stages move toward q7; fault sticks q0 at zero on the loopback path.
  always @(posedge clk or posedge reset) begin
    if (reset)      sr_model <= '0;
    else if (sr_en) sr_model <= {sr_model[W-2:0], sr_d};
  end
  assign sr_q = fault ? (sr_model & ~8'h01) : sr_model;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && done_valid) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("done_data", done_data, e.data);
        check("done_id",   done_id,   e.id);
        check("done_err",  done_err,  e.err);
      end
    end
  end

  // Caller enters at a negedge; returns #1 after the handshake edge (SHIFT cycle 1).
  task automatic send(input logic id, input logic [W-1:0] data);
    bit ok = 0;
    if (id) begin req1_data = data; req1_valid = 1'b1; end
    else    begin req0_data = data; req0_valid = 1'b1; end
    for (int i = 0; i < 50; i++) begin
      #1;
      if (id ? req1_ready : req0_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    check("handshake_seen", ok, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // Watches n grants with fixed-valid requesters; ids[k] is the expected winner of grant k.
  task automatic watch_grants(input int n, input logic [7:0] ids);
    int k = 0;
    int last = 0;
    for (int cyc = 0; cyc < n * 10 + 20 && k < n; cyc++) begin
      #1;
      if (req0_ready || req1_ready) begin
        check("single_ready", req0_ready & req1_ready, 0);
        check("grant_id", req1_ready, ids[k]);
        if (k > 0) begin
          check("grant_spacing", cyc - last, 10);
          check("done_with_handshake", done_valid, 1);
        end
        last = cyc;
        k++;
      end
      if (k < n) @(negedge clk);
    end
    check("grant_count", k, n);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #2;
      if (exp_q.size() == 0) break;
    end
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin
    logic [W-1:0] word;
    int           seen_before;
    fault      = 1'b0;
    reset      = 1'b1;
    req0_valid = 1'b1; req0_data = 8'h11;
    req1_valid = 1'b1; req1_data = 8'h22;

    // Reset held with both requesters asking.
    repeat (3) @(negedge clk);
    #1;
    check("rst_req0_ready", req0_ready, 0);
    check("rst_req1_ready", req1_ready, 0);
    check("rst_sr_en", sr_en, 0);
    check("rst_sr_d", sr_d, 0);
    check("rst_busy", busy, 0);
    check("rst_done_valid", done_valid, 0);
    check("rst_done_data", done_data, 0);
    check("rst_done_id", done_id, 0);
    check("rst_done_err", done_err, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("first_tie_req0_ready", req0_ready, 1);
    check("first_tie_req1_ready", req1_ready, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Single word, serial bit order and result timing.
    @(negedge clk);
    word = 8'hA5;
    exp_q.push_back('{data: 8'hA5, id: 1'b0, err: 1'b0});
    send(1'b0, word);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      check("shift_sr_en", sr_en, 1);
      check("shift_sr_d", sr_d, word[W-1-i]);
    end
    @(negedge clk);
    check("check_sr_en", sr_en, 0);
    check("check_sr_d", sr_d, 0);
    check("check_busy", busy, 1);
    @(negedge clk);
    check("done_pulse_cycle10", done_valid, 1);
    check("done_cycle_idle", busy, 0);
    @(negedge clk);
    check("done_pulse_ends", done_valid, 0);
    check("done_data_held", done_data, 8'hA5);

    // Back-to-back from requester 1 alone.
    for (int i = 0; i < 3; i++) exp_q.push_back('{data: 8'h96, id: 1'b1, err: 1'b0});
    req1_data  = 8'h96;
    req1_valid = 1'b1;
    watch_grants(3, 8'b0000_0111);
    drain();

    // Contention: requester 1 was served last, so the order is 0,1,0,1.
    exp_q.push_back('{data: 8'h3C, id: 1'b0, err: 1'b0});
    exp_q.push_back('{data: 8'hC3, id: 1'b1, err: 1'b0});
    exp_q.push_back('{data: 8'h3C, id: 1'b0, err: 1'b0});
    exp_q.push_back('{data: 8'hC3, id: 1'b1, err: 1'b0});
    req0_data = 8'h3C; req0_valid = 1'b1;
    req1_data = 8'hC3; req1_valid = 1'b1;
    watch_grants(4, 8'b0000_1010);
    drain();

    // Loopback fault on q0.
    fault = 1'b1;
    exp_q.push_back('{data: 8'hA4, id: 1'b0, err: 1'b1});
    send(1'b0, 8'hA5);
    drain();
    fault = 1'b0;

    // Reset in SHIFT cycle 4 aborts the word silently.
    seen_before = done_seen;
    @(negedge clk);
    send(1'b0, 8'h81);
    repeat (4) @(negedge clk);
    check("mid_sr_en_before", sr_en, 1);
    reset = 1'b1;
    #1;
    check("mid_sr_en_async", sr_en, 0);
    check("mid_busy_async", busy, 0);
    check("mid_sr_d_async", sr_d, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (14) @(negedge clk);
    check("abort_no_done", done_seen, seen_before);
    exp_q.push_back('{data: 8'h5A, id: 1'b0, err: 1'b0});
    send(1'b0, 8'h5A);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/shift_reg_seq_ctrl.md
# shift_reg_seq_ctrl

Sequencer and two-port round-robin arbiter for the serial-in, parallel-out `shift_register`. It accepts parallel words from two requesters over valid/ready handshakes and shifts each word MSB-first into the register. After the last bit it captures the register's parallel outputs `q7..q0` and returns them with a loopback-mismatch flag. It sits between the requesting logic and the `shift_register` instance, and drives that instance's `d` input and shift strobe.

## Interface
- `WIDTH`, default 8: word width; equals the shift register depth, so stages `q0..q(WIDTH-1)` are used.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; also drives the `shift_register` reset.
- `req0_valid` in 1: requester 0 has a word.
- `req0_data` in WIDTH: requester 0 word; must be stable while `req0_valid` is high.
- `req0_ready` out 1: requester 0 word accepted this cycle.
- `req1_valid`, `req1_data`, `req1_ready`: same as the requester-0 ports, for requester 1.
- `sr_d` out 1: serial bit to `shift_register.d`.
- `sr_en` out 1: shift strobe to the register; the register shifts on a clk edge only when this is high.
- `sr_q` in WIDTH: `{q(WIDTH-1), …, q1, q0}` from the register.
- `done_valid` out 1: one-cycle pulse; a result is present.
- `done_data` out WIDTH: captured `sr_q`.
- `done_id` out 1: requester that owned the result.
- `done_err` out 1: captured `sr_q` differs from the word that was sent.
- `busy` out 1: the FSM is not in IDLE.

## Operation
- FSM states: IDLE, SHIFT, CHECK.
- **IDLE**
  - If either valid is high, arbitrate round-robin. The requester not granted last wins a tie; a lone requester always wins.
  - The grant is combinational: `reqN_ready` = IDLE & grantN. At most one ready is high.
  - On the handshake edge: latch data and id, update `last_grant`, clear `cnt`, go to SHIFT.
- **SHIFT**
  - `sr_en`=1 and `sr_d` = `data[WIDTH-1-cnt]`.
  - `cnt` increments on each edge. At `cnt`==WIDTH-1, go to CHECK, so SHIFT lasts exactly WIDTH cycles.
  - Data ordering: `q0` receives `d` and each stage shifts toward `q(WIDTH-1)`. After WIDTH shifts, `sr_q` equals the sent word.
- **CHECK**
  - `sr_en`=0.
  - On the edge leaving CHECK: `done_valid`<=1, `done_data`<=`sr_q`, `done_id`<=latched id, `done_err`<=(`sr_q` != latched data).
  - Next state is IDLE.
- Outputs
  - `done_valid` is a registered single-cycle pulse. `done_data`, `done_id` and `done_err` hold their values until the next result.
  - `sr_d` is 0 whenever `sr_en`=0.
  - `busy` is high in SHIFT and CHECK.
  - `cnt` is clog2(WIDTH) bits wide and never wraps past WIDTH-1.
- Requesters must hold valid and data until ready. Deasserting valid before ready simply withdraws the request; no error is raised.
- Reset values, applied immediately and asynchronously:
  - state=IDLE, `cnt`=0.
  - `last_grant`=1, so requester 0 wins the first tie.
  - `sr_en`=0, `sr_d`=0, `busy`=0.
  - `done_valid`=0, `done_data`=0, `done_id`=0, `done_err`=0.
  - Both readies are 0 while reset is high.
- Reset mid-SHIFT or mid-CHECK aborts the transfer: no `done_valid` is produced for that word and it is not retried. The shift register clears from the same reset.

## Timing
- Handshake at edge E0.
- Cycles 1..WIDTH are SHIFT; the register updates at edges E1..E(WIDTH).
- Cycle WIDTH+1 is CHECK.
- `done_valid` is high in cycle WIDTH+2, which is also IDLE.
- The next handshake can occur at the edge that ends cycle WIDTH+2. That gives one word per WIDTH+2 cycles (10 for WIDTH=8).
- A `done_valid` pulse and a new handshake in the same cycle are legal and independent.

## Test plan
- **Reset:** hold `reset`=1 with both valids high -> all outputs 0 and both readies 0. Release reset -> `req0_ready`=1 in the first cycle.
- **Single word:** `req0_data`=0xA5 -> `sr_en` high for 8 cycles with `sr_d` = 1,0,1,0,0,1,0,1. Then `done_valid` pulses at cycle 10 with `done_data`=0xA5, `done_id`=0, `done_err`=0.
- **Contention:** both valid and held, `req0`=0x3C and `req1`=0xC3 -> grants in order 0,1,0,1, handshakes 10 cycles apart, each `done_data` matching its `done_id`.
- **Loopback fault:** bench forces `sr_q[0]` stuck at 0 and sends 0xA5 -> `done_data`=0xA4, `done_err`=1.
- **Reset mid-transfer:** assert reset in SHIFT cycle 4 -> `sr_en` and `busy` drop without a clock, and no `done_valid` follows. After release, a 0x5A transfer completes normally.
- **Back-to-back single requester:** `req1` continuously valid -> a handshake every 10 cycles. Each `done_valid` coincides with the IDLE cycle of the next handshake, with `done_id`=1 throughout.
